operand_fetch_stage: RTL and testbench

- Decode/register-read stage sitting directly upstream of register_file in KGP_miniRISC.
- Accepts decoded instructions and drives register_file read addresses.
- Resolves operands from the register file, from the writeback port (same-cycle write bypass), or from the EX result (forwarding); detects load-use hazards.
- Presents captured operands to the execute stage through a one-entry valid/ready output register.

---
 rtl/operand_fetch_stage.sv | 132 +++++++++++++
 tb/tb_operand_fetch_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - register-read stage with bypass, forwarding, load-use stall and output register
module operand_fetch_stage #(
    parameter int DATA_W         = 32,
    parameter int REG_AW         = 5,
    parameter int CTRL_W         = 8,
    parameter int ZERO_HARDWIRED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic              in_use_rs,
    input  logic              in_use_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [REG_AW-1:0] rf_rs,
    output logic [REG_AW-1:0] rf_rt,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              ex_regWrite,
    input  logic              ex_isLoad,
    input  logic [REG_AW-1:0] ex_reg,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_imm,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              stall
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic              rs_zero, rt_zero;
    logic              ex_hit_rs, ex_hit_rt;
    logic              wb_hit_rs, wb_hit_rt;
    logic              accept;
    logic [DATA_W-1:0] op1_sel, op2_sel;

    // Register 0 reads as constant zero and never matches a bypass source
    assign rs_zero = (ZERO_HARDWIRED != 0) && (in_rs == '0);
    assign rt_zero = (ZERO_HARDWIRED != 0) && (in_rt == '0);

    assign ex_hit_rs = ex_regWrite && (ex_reg == in_rs) && !rs_zero;
    assign ex_hit_rt = ex_regWrite && (ex_reg == in_rt) && !rt_zero;
    assign wb_hit_rs = wb_regWrite && (wb_reg == in_rs) && !rs_zero;
    assign wb_hit_rt = wb_regWrite && (wb_reg == in_rt) && !rt_zero;

    // Addresses go straight to the register file so its read data arrives this cycle
    assign rf_rs = in_rs;
    assign rf_rt = in_rt;

    // A load in EX has no result yet; only operands actually read can stall
    assign stall = in_valid && ex_isLoad &&
                   ((in_use_rs && ex_hit_rs) || (in_use_rt && ex_hit_rt));

    assign in_ready = (!valid_q || out_ready) && !stall;
    assign accept   = in_valid && in_ready;

    // Operand priority: zero reg, EX forward (younger), WB bypass, register file
    always_comb begin
        op1_sel = rf_data1;
        if (rs_zero)                       op1_sel = '0;
        else if (ex_hit_rs && !ex_isLoad)  op1_sel = ex_data;
        else if (wb_hit_rs)                op1_sel = wb_data;

        op2_sel = rf_data2;
        if (rt_zero)                       op2_sel = '0;
        else if (ex_hit_rt && !ex_isLoad)  op2_sel = ex_data;
        else if (wb_hit_rt)                op2_sel = wb_data;
    end

    // Output register: load on accept, drop valid when drained without a replacement
    always_comb begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        if (accept) begin
            valid_d = 1'b1;
            op1_d   = op1_sel;
            op2_d   = op2_sel;
            rd_d    = in_rd;
            imm_d   = in_imm;
            ctrl_d  = in_ctrl;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State update with asynchronous active-low reset discarding any pending bundle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign out_rd    = rd_q;
    assign out_imm   = imm_q;
    assign out_ctrl  = ctrl_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic        in_use_rs = 1'b0, in_use_rt = 1'b0;
    logic [31:0] in_imm = '0;
    logic [7:0]  in_ctrl = '0;
    logic [4:0]  rf_rs, rf_rt;
    logic [31:0] rf_data1, rf_data2;
    logic        ex_regWrite = 1'b0, ex_isLoad = 1'b0;
    logic [4:0]  ex_reg = '0;
    logic [31:0] ex_data = '0;
    logic        wb_regWrite = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_op1, out_op2, out_imm;
    logic [4:0]  out_rd;
    logic [7:0]  out_ctrl;
    logic        stall;

    logic [31:0] rf_mem [0:31];
    assign rf_data1 = rf_mem[rf_rs];
    assign rf_data2 = rf_mem[rf_rt];

    int vectors = 0;
    int miscompares = 0;

    // Reference state: what the execute stage should currently see
    logic        m_valid = 1'b0;
    logic [31:0] m_op1 = '0, m_op2 = '0, m_imm = '0;
    logic [4:0]  m_rd = '0;
    logic [7:0]  m_ctrl = '0;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_regWrite(ex_regWrite), .ex_isLoad(ex_isLoad), .ex_reg(ex_reg), .ex_data(ex_data),
        .wb_regWrite(wb_regWrite), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
        .out_imm(out_imm), .out_ctrl(out_ctrl), .stall(stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Value the architectural register file would deliver for src this cycle
    function automatic logic [31:0] resolve(input logic [4:0] src);
        if (src == 5'd0)                                           return 32'd0;
        if (ex_regWrite && !ex_isLoad && ex_reg == src)            return ex_data;
        if (wb_regWrite && wb_reg == src)                          return wb_data;
        return rf_mem[src];
    endfunction

    function automatic logic model_stall();
        logic hit_rs, hit_rt;
        hit_rs = in_use_rs && ex_regWrite && ex_reg == in_rs && in_rs != 5'd0;
        hit_rt = in_use_rt && ex_regWrite && ex_reg == in_rt && in_rt != 5'd0;
        return in_valid && ex_isLoad && (hit_rs || hit_rt);
    endfunction

    // Inputs are set just after a rising edge; check comb outputs, clock once, check registers
    task automatic step();
        logic es, er;
        #2;
        es = model_stall();
        er = (!m_valid || out_ready) && !es;
        chk("stall", {31'd0, stall}, {31'd0, es});
        chk("in_ready", {31'd0, in_ready}, {31'd0, er});
        chk("rf_rs", {27'd0, rf_rs}, {27'd0, in_rs});
        chk("rf_rt", {27'd0, rf_rt}, {27'd0, in_rt});
        if (in_valid && er) begin
            m_valid = 1'b1;
            m_op1   = resolve(in_rs);
            m_op2   = resolve(in_rt);
            m_rd    = in_rd;
            m_imm   = in_imm;
            m_ctrl  = in_ctrl;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_op1", out_op1, m_op1);
        chk("out_op2", out_op2, m_op2);
        chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
        chk("out_imm", out_imm, m_imm);
        chk("out_ctrl", {24'd0, out_ctrl}, {24'd0, m_ctrl});
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_op1"}, out_op1, 32'd0);
        chk({name, "_op2"}, out_op2, 32'd0);
        chk({name, "_rd"}, {27'd0, out_rd}, 32'd0);
        chk({name, "_imm"}, out_imm, 32'd0);
        chk({name, "_ctrl"}, {24'd0, out_ctrl}, 32'd0);
    endtask

    typedef struct {
        logic [4:0]  rs, rt;
        logic        use_rs, use_rt;
        logic        exw, exld;
        logic [4:0]  exreg;
        logic [31:0] exdata;
        logic        wbw;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic        e_stall;
        logic [31:0] e_op1, e_op2;
    } vec_t;

    vec_t tbl [9];

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd100 + 32'(3 * i);
        rf_mem[0] = 32'hdead_0000;
        rf_mem[1] = 32'd68;
        rf_mem[2] = 32'd82;

        //          rs  rt  urs urt exw exl exreg exdata  wbw wbreg wbdata  stall op1          op2
        tbl[0] = '{5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 32'd0,   0, 5'd0, 32'd0,   0, 32'd68,   32'd82};
        tbl[1] = '{5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 32'd0,   1, 5'd1, 32'd99,  0, 32'd99,   32'd82};
        tbl[2] = '{5'd1, 5'd2, 1, 1, 1, 0, 5'd2, 32'd7,   1, 5'd2, 32'd5,   0, 32'd68,   32'd7};
        tbl[3] = '{5'd0, 5'd0, 1, 1, 1, 0, 5'd0, 32'd7,   1, 5'd0, 32'd5,   0, 32'd0,    32'd0};
        tbl[4] = '{5'd1, 5'd2, 1, 0, 1, 1, 5'd1, 32'd7,   0, 5'd0, 32'd0,   1, 32'd0,    32'd0};
        tbl[5] = '{5'd1, 5'd2, 0, 1, 1, 1, 5'd1, 32'd7,   0, 5'd0, 32'd0,   0, 32'd68,   32'd82};
        tbl[6] = '{5'd3, 5'd3, 1, 1, 0, 0, 5'd0, 32'd0,   1, 5'd3, 32'h55,  0, 32'h55,   32'h55};
        tbl[7] = '{5'd0, 5'd2, 1, 1, 1, 1, 5'd0, 32'd7,   0, 5'd0, 32'd0,   0, 32'd0,    32'd82};
        tbl[8] = '{5'd5, 5'd6, 1, 1, 1, 0, 5'd6, 32'h1234, 0, 5'd0, 32'd0,  0, 32'd115,  32'h1234};

        // Reset held with a pending instruction: nothing may be captured
        in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd9;
        in_imm = 32'hcafe; in_ctrl = 8'h5a; in_use_rs = 1'b1; in_use_rt = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check_all_zero("reset");
        end
        rst = 1'b1;
        step();
        chk("first_accept_valid", {31'd0, out_valid}, 32'd1);

        // Table vectors, each entered with an empty or draining output register
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_rs = tbl[i].rs; in_rt = tbl[i].rt;
            in_use_rs = tbl[i].use_rs; in_use_rt = tbl[i].use_rt;
            ex_regWrite = tbl[i].exw; ex_isLoad = tbl[i].exld;
            ex_reg = tbl[i].exreg; ex_data = tbl[i].exdata;
            wb_regWrite = tbl[i].wbw; wb_reg = tbl[i].wbreg; wb_data = tbl[i].wbdata;
            in_rd = 5'(i + 10); in_imm = 32'h1000 + 32'(i); in_ctrl = 8'(i * 17);
            #2;
            chk("tbl_stall", {31'd0, stall}, {31'd0, tbl[i].e_stall});
            step();
            if (tbl[i].e_stall) begin
                chk("tbl_bubble", {31'd0, out_valid}, 32'd0);
                ex_isLoad = 1'b0; ex_regWrite = 1'b0;
                step();
                chk("tbl_release_op1", out_op1, rf_mem[tbl[i].rs]);
            end else begin
                chk("tbl_op1", out_op1, tbl[i].e_op1);
                chk("tbl_op2", out_op2, tbl[i].e_op2);
            end
        end

        // Backpressure: three frozen cycles, then back-to-back accepts
        ex_regWrite = 1'b0; ex_isLoad = 1'b0; wb_regWrite = 1'b0;
        in_rs = 5'd4; in_rt = 5'd5; in_imm = 32'haaaa;
        step();
        out_ready = 1'b0; in_imm = 32'hbbbb; in_rd = 5'd20;
        repeat (3) begin
            step();
            chk("frozen_imm", out_imm, 32'haaaa);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_imm", out_imm, 32'hbbbb + 32'(k));
            in_imm = 32'hbbbb + 32'(k + 1);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            in_valid    = 1'($urandom_range(0, 3) != 0);
            out_ready   = 1'($urandom_range(0, 3) != 0);
            in_rs       = 5'($urandom_range(0, 3));
            in_rt       = 5'($urandom_range(0, 3));
            in_use_rs   = 1'($urandom);
            in_use_rt   = 1'($urandom);
            in_rd       = 5'($urandom);
            in_imm      = $urandom;
            in_ctrl     = 8'($urandom);
            ex_regWrite = 1'($urandom);
            ex_isLoad   = 1'($urandom_range(0, 3) == 0);
            ex_reg      = 5'($urandom_range(0, 3));
            ex_data     = $urandom;
            wb_regWrite = 1'($urandom);
            wb_reg      = 5'($urandom_range(0, 3));
            wb_data     = $urandom;
            rf_mem[$urandom_range(1, 3)] = $urandom;
            step();
        end

        // Asynchronous reset mid-transfer drops the pending bundle immediately
        ex_regWrite = 1'b0; ex_isLoad = 1'b0; wb_regWrite = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0; in_rs = 5'd1; in_rt = 5'd2;
        in_imm = 32'h7777;
        step();
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_imm = '0; m_ctrl = '0;
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1;
        step();
        chk("post_reset_imm", out_imm, 32'h7777);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
